// File: rtl/sort_result_streamer.sv
// sort_result_streamer
//   Sits behind the parallel sorter. When the sorter's done flag rises, the
//   N-element sorted array is captured and streamed out one element per
//   valid/ready handshake, index 0 first, with m_last marking element N-1.
//   While streaming it also checks the sorter's work: a descent between
//   consecutive elements sets order_err, and a done edge that arrives while
//   a frame is still being held or streamed is dropped and sets overrun.
//
// Handshake: m_valid/m_data/m_index/m_last are presented together and hold
//   stable until a cycle in which m_valid & m_ready are both high; that
//   cycle is the transfer. m_valid never drops without a transfer.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   done_in        sorter done flag (rising edge starts a capture)
//   data_in        N x WIDTH array, element i at data_in[i*WIDTH +: WIDTH]
//   m_valid/m_ready/m_data/m_index/m_last   output stream
//   busy           a frame is held or streaming
//   order_err      sticky, frame was not non-decreasing
//   overrun        sticky, a frame was dropped while busy
//   clr_err        synchronous clear of order_err and overrun
//   frame_count    frames fully streamed, wraps
//   state_dbg      current FSM state (0 = IDLE, 1 = STREAM)
module sort_result_streamer #(
  parameter int N     = 6,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   done_in,
  input  logic [WIDTH*N-1:0]     data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [$clog2(N)-1:0]   m_index,
  output logic                   m_last,
  output logic                   busy,
  output logic                   order_err,
  output logic                   overrun,
  input  logic                   clr_err,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   state_dbg
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [WIDTH-1:0] buf_q [N];
  logic [WIDTH-1:0] buf_n [N];
  logic             done_d;
  logic [CNT_W-1:0] cnt_n;
  logic             order_n, ovr_n;
  logic             done_rise, accept, capture, set_ord, set_ovr;

  assign state_dbg = state_q;

  always_comb begin
    done_rise = done_in & ~done_d;
    accept    = m_valid & m_ready;
    state_n   = state_q;
    idx_n     = idx_q;
    buf_n     = buf_q;
    cnt_n     = frame_count;
    capture   = 1'b0;
    set_ord   = 1'b0;
    set_ovr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_rise) capture = 1'b1;
      end
      STREAM: begin
        if (accept) begin
          if ((idx_q != '0) && (buf_q[idx_q] < buf_q[idx_q - 1'b1]))
            set_ord = 1'b1;
          if (idx_q == LAST_IDX) begin
            cnt_n = frame_count + 1'b1;
            // A done edge on the final transfer starts the next frame with
            // no bubble; it is not an overrun.
            if (done_rise) capture = 1'b1;
            else           state_n = IDLE;
          end else begin
            idx_n = idx_q + 1'b1;
            if (done_rise) set_ovr = 1'b1;
          end
        end else if (done_rise) begin
          set_ovr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (capture) begin
      for (int i = 0; i < N; i++) buf_n[i] = data_in[i*WIDTH +: WIDTH];
      idx_n   = '0;
      state_n = STREAM;
    end

    // Set has priority over a coincident clear.
    order_n = set_ord | (order_err & ~clr_err);
    ovr_n   = set_ovr | (overrun & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      done_d      <= 1'b0;
      frame_count <= '0;
      order_err   <= 1'b0;
      overrun     <= 1'b0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      m_data      <= '0;
      m_index     <= '0;
      m_last      <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      buf_q       <= buf_n;
      done_d      <= done_in;
      frame_count <= cnt_n;
      order_err   <= order_n;
      overrun     <= ovr_n;
      // Stream outputs are registered from the next-state view so they line
      // up with state_q/idx_q in the same cycle.
      m_valid     <= (state_n == STREAM);
      busy        <= (state_n == STREAM);
      m_data      <= (state_n == STREAM) ? buf_n[idx_n] : '0;
      m_index     <= (state_n == STREAM) ? idx_n : '0;
      m_last      <= (state_n == STREAM) && (idx_n == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_sort_result_streamer.sv
module tb_sort_result_streamer;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           clk, rst_n, done_in, m_ready, clr_err;
  logic [W*N-1:0] data_in;
  logic           m_valid, m_last, busy, order_err, overrun, state_dbg;
  logic [W-1:0]   m_data;
  logic [2:0]     m_index;
  logic [CW-1:0]  frame_count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt;

  sort_result_streamer #(.N(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .order_err(order_err), .overrun(overrun),
    .clr_err(clr_err), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W*N-1:0] mk(input logic [W-1:0] f[N]);
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = f[i];
    return r;
  endfunction

  // driver tasks (all return at a falling edge)
  task automatic do_reset();
    rst_n = 1'b0; done_in = 1'b0; m_ready = 1'b0; clr_err = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = '0;
  endtask

  task automatic start_frame(input logic [W*N-1:0] d);
    data_in = d; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({m_valid, m_data, m_index, m_last, busy, order_err, overrun, frame_count, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b b=%b oe=%b ov=%b fc=%0d st=%b expected all 0",
               m_valid, m_data, m_index, m_last, busy, order_err, overrun, frame_count, state_dbg);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] f[N] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd200};
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) exp_q.push_back(f[i]);
    m_ready = 1'b1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle_valid: got %b expected 0", m_valid);
    end
    start_frame(mk(f));
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if ({m_valid, m_data, m_index, m_last, busy} !== {1'b1, e, 3'(i), (i == N-1), 1'b1}) begin
        miscompares++;
        $display("FAIL basic_elem%0d: got v=%b d=%0d i=%0d l=%b b=%b expected v=1 d=%0d i=%0d l=%b b=1",
                 i, m_valid, m_data, m_index, m_last, busy, e, i, (i == N-1));
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if ({m_valid, busy, order_err, frame_count, state_dbg} !== {1'b0, 1'b0, 1'b0, exp_cnt, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_end: got v=%b b=%b oe=%b fc=%0d st=%b expected v=0 b=0 oe=0 fc=%0d st=0",
               m_valid, busy, order_err, frame_count, state_dbg, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] f[N] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd200};
    int acc = 0;
    int idx = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(f[i]);
    m_ready = 1'b0;
    start_frame(mk(f));
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      vectors++;
      if ({m_valid, m_data, m_index, m_last} !== {1'b1, exp_q[0], 3'(idx), (idx == N-1)}) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: got v=%b d=%0d i=%0d l=%b expected v=1 d=%0d i=%0d l=%b",
                 k, m_valid, m_data, m_index, m_last, exp_q[0], idx, (idx == N-1));
      end
      m_ready = (k % 3 == 0);
      @(negedge clk);
      if (m_ready) begin
        void'(exp_q.pop_front());
        acc++; idx++;
      end
    end
    m_ready = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if ({acc, m_valid, frame_count} !== {32'd6, 1'b0, exp_cnt}) begin
      miscompares++;
      $display("FAIL bp_end: got accepts=%0d v=%b fc=%0d expected accepts=6 v=0 fc=%0d",
               acc, m_valid, frame_count, exp_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_overrun_b2b();
    logic [W-1:0] f1[N] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    logic [W-1:0] f2[N] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [W-1:0] jk[N] = '{8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94};
    m_ready = 1'b1;
    start_frame(mk(f1));
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({m_data, m_index} !== {f1[i], 3'(i)}) begin
        miscompares++;
        $display("FAIL ovr_f1_elem%0d: got d=%0d i=%0d expected d=%0d i=%0d", i, m_data, m_index, f1[i], i);
      end
      if (i == 2) begin data_in = mk(jk); done_in = 1'b1; end
      if (i == 3) begin
        done_in = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
          miscompares++; $display("FAIL ovr_set: got %b expected 1", overrun);
        end
      end
      if (i == 4) clr_err = 1'b1;
      if (i == 5) begin
        clr_err = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
          miscompares++; $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        data_in = mk(f2); done_in = 1'b1;
      end
      @(negedge clk);
    end
    done_in = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({m_valid, m_data, m_index, overrun} !== {1'b1, f2[i], 3'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_elem%0d: got v=%b d=%0d i=%0d ov=%b expected v=1 d=%0d i=%0d ov=0",
                 i, m_valid, m_data, m_index, overrun, f2[i], i);
      end
      if (i == 0) begin
        vectors++;
        if (frame_count !== exp_cnt) begin
          miscompares++; $display("FAIL b2b_count1: got %0d expected %0d", frame_count, exp_cnt);
        end
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if ({m_valid, frame_count} !== {1'b0, exp_cnt}) begin
      miscompares++;
      $display("FAIL b2b_end: got v=%b fc=%0d expected v=0 fc=%0d", m_valid, frame_count, exp_cnt);
    end
  endtask

  task automatic test_order_err();
    logic [W-1:0] f[N] = '{8'd1, 8'd4, 8'd2, 8'd8, 8'd8, 8'd9};
    logic [W-1:0] g[N] = '{8'd5, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
    m_ready = 1'b1;
    start_frame(mk(f));
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({m_data, order_err} !== {f[i], (i == 3)}) begin
        miscompares++;
        $display("FAIL order_f_elem%0d: got d=%0d oe=%b expected d=%0d oe=%b", i, m_data, order_err, f[i], (i == 3));
      end
      if (i == 3) clr_err = 1'b1;
      if (i == 4) clr_err = 1'b0;
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if ({order_err, frame_count} !== {1'b0, exp_cnt}) begin
      miscompares++;
      $display("FAIL order_equal_pair: got oe=%b fc=%0d expected oe=0 fc=%0d", order_err, frame_count, exp_cnt);
    end
    // clear coinciding with a descent: the set must win
    start_frame(mk(g));
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({m_data, order_err} !== {g[i], (i >= 2)}) begin
        miscompares++;
        $display("FAIL order_g_elem%0d: got d=%0d oe=%b expected d=%0d oe=%b", i, m_data, order_err, g[i], (i >= 2));
      end
      clr_err = (i == 1);
      @(negedge clk);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if ({order_err, frame_count} !== {1'b0, exp_cnt}) begin
      miscompares++;
      $display("FAIL order_idle_clear: got oe=%b fc=%0d expected oe=0 fc=%0d", order_err, frame_count, exp_cnt);
    end
  endtask

  task automatic test_held_done_and_wrap();
    logic [W-1:0] f[N] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [CW-1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int acc = 0;
    do_reset();
    m_ready = 1'b1;
    data_in = mk(f); done_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) acc++;
    end
    done_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (m_valid) acc++;
    end
    vectors++;
    if ({acc, frame_count} !== {32'd6, seq[0]}) begin
      miscompares++;
      $display("FAIL held_done: got accepts=%0d fc=%0d expected accepts=6 fc=%0d", acc, frame_count, seq[0]);
    end
    for (int n = 1; n < 5; n++) begin
      start_frame(mk(f));
      repeat (N) @(negedge clk);
      vectors++;
      if ({m_valid, frame_count} !== {1'b0, seq[n]}) begin
        miscompares++;
        $display("FAIL wrap_frame%0d: got v=%b fc=%0d expected v=0 fc=%0d", n, m_valid, frame_count, seq[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] f[N] = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    int stray = 0;
    do_reset();
    m_ready = 1'b1;
    start_frame(mk(f));
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_valid, m_index} !== {1'b1, 3'd3}) begin
      miscompares++; $display("FAIL rstmid_pos: got v=%b i=%0d expected v=1 i=3", m_valid, m_index);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_valid, m_data, m_index, m_last, busy, order_err, overrun, frame_count, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got v=%b d=%h i=%0d l=%b b=%b oe=%b ov=%b fc=%0d expected all 0",
               m_valid, m_data, m_index, m_last, busy, order_err, overrun, frame_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) stray++;
    end
    vectors++;
    if ({stray, frame_count} !== {32'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL rstmid_after: got valid_cycles=%0d fc=%0d expected 0 and 0", stray, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun_b2b();
    test_order_err();
    test_held_done_and_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
